instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Boot-time writer for the instruction memory that the pipeline's fetch stage reads.
- Accepts a byte stream of SimpleRisc machine code (.encode output) over a valid/ready handshake, packs the bytes into 32-bit words, and writes them to consecutive word addresses.
- Holds the processor in reset until the image is loaded, then releases it.

Parameters:
- ADDR_WIDTH, 10, instruction memory word-address width (depth 2^ADDR_WIDTH words)
- BASE_ADDR, 0, first word address written

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  loader accepts a byte this cycle
- in_byte  input  8  machine-code byte
- in_last  input  1  qualifies the final byte of the image; sampled only on transfer
- reload  input  1  one-cycle pulse; restarts loading from DONE or ERROR
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address for the write
- imem_wdata  output  32  word to write
- cpu_reset  output  1  active-high reset to the processor core
- load_done  output  1  image fully written
- word_count  output  ADDR_WIDTH+1  words written since load start
- overflow_err  output  1  image exceeded memory depth; sticky

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, byte index=0.
  - cpu_reset=1, load_done=0, overflow_err=0.
- A transfer occurs when in_valid and in_ready are both high on a rising edge.
- Byte packing is little-endian: byte index k (0..3) goes to bits [8k+7:8k] of the assembly register.
- IDLE:
  - in_ready=1, cpu_reset=1.
  - The first transfer is packed as byte 0 and the state moves to LOAD.
  - If that first transfer has in_last=1, the state moves to FLUSH instead (see LOAD rule for in_last).
- LOAD:
  - in_ready=1, cpu_reset=1.
  - On the 4th byte of a word: the assembled word goes to imem_wdata, the byte index wraps to 0, and the state moves to WRITE.
  - If in_last=1 arrives on a byte other than the 4th: the unfilled upper bytes are zero-padded, the word goes to imem_wdata, and the state moves to FLUSH.
  - If in_last=1 arrives on the 4th byte: same as the in_last case above; the state moves to FLUSH.
- WRITE:
  - in_ready=0, imem_we=1 for exactly one cycle at the current imem_addr.
  - Next cycle: imem_addr+1, word_count+1, return to LOAD.
  - If the write just used address 2^ADDR_WIDTH-1, the next state is FULL instead of LOAD.
- FLUSH:
  - in_ready=0, imem_we=1 for one cycle.
  - word_count+1, then move to DONE.
- FULL:
  - in_ready=1, cpu_reset=1; no further writes.
  - Any further transfer moves to ERROR.
  - Exception: a transfer with in_last=1 and zero bytes pending is impossible by construction. The in_last flag is carried on the final word's 4th byte, so a full image ends via FLUSH.
- DONE:
  - in_ready=0, load_done=1, cpu_reset=0.
  - imem_we=0; imem_addr and word_count hold.
- ERROR:
  - overflow_err=1, cpu_reset=1, load_done=0.
  - in_ready=1, and bytes are dropped so the source can drain.
  - No writes.
- reload:
  - In DONE or ERROR, a reload pulse clears the counters, flags, and address back to reset values (cpu_reset=1) and moves to IDLE.
  - reload is ignored in IDLE, LOAD, WRITE, FLUSH and FULL.
- Latency: a word's imem_we is asserted the cycle after its final byte transfer.
- Throughput: 4 bytes per 5 cycles.
- word_count saturates at 2^ADDR_WIDTH.
- imem_addr wraps only through reload, never arithmetically.
- An asynchronous reset mid-write aborts the write immediately: imem_we drops without waiting for the clock, and memory contents are undefined for that word.

Test Plan:
- Stream bytes 0x01,0x00,0xA0,0x10 with in_last on the 4th, in_valid held high → one imem_we at addr 0 with wdata 0x10A00001; word_count=1; load_done=1 and cpu_reset=0 the cycle after.
- 8-byte image streamed continuously → imem_we at addr 0 then addr 1, 5 cycles apart; in_ready low exactly during the write cycle; DONE with word_count=2.
- 6 bytes 0x11..0x16 with in_last on byte 6 → words 0x14131211 at addr 0 and 0x00001615 at addr 1 (zero-padded).
- ADDR_WIDTH=2, 17 bytes → 4 writes (addr 0..3), then overflow_err=1, cpu_reset stays 1, in_ready=1, no 5th write; reload → IDLE with all outputs at reset values.
- Pull reset low between the 2nd and 3rd byte → outputs at reset values asynchronously; a fresh 4-byte image then writes addr 0 correctly with no stale bytes.
- in_valid toggling randomly with in_last on byte 12 → words identical to the continuous-stream case; no write issued while in_valid is low mid-word.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream to instruction-memory word writer
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  input  logic                  in_last,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  overflow_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FLUSH,
    S_FULL,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_idx;
  logic [31:0]           r_asm;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_count;

  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_emit;
  logic [31:0]           w_word;
  logic [ADDR_WIDTH:0]   w_count_inc;

  // Bytes are only taken while packing, or while full/errored so the source can drain.
  assign w_ready = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                   (r_state == S_FULL) || (r_state == S_ERROR);
  assign w_xfer  = in_valid && w_ready;

  // Little-endian packing; the assembly register only ever holds the lower bytes
  // already received, so a short final word is zero-padded for free.
  assign w_word      = r_asm | (32'(in_byte) << {r_idx, 3'b000});
  assign w_emit      = in_last || (r_idx == 2'd3);
  assign w_count_inc = (r_count == MAX_COUNT) ? r_count : r_count + (ADDR_WIDTH+1)'(1);

  assign in_ready   = w_ready;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_count;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; imem_we is decoded so reset drops it at once.
  always_comb begin
    w_next       = r_state;
    imem_we      = 1'b0;
    cpu_reset    = 1'b1;
    load_done    = 1'b0;
    overflow_err = 1'b0;
    case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_xfer) begin
          if (in_last) begin
            w_next = S_FLUSH;
          end else if (r_idx == 2'd3) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_LOAD;
          end
        end
      end
      S_WRITE: begin
        imem_we = 1'b1;
        w_next  = (r_addr == LAST_ADDR) ? S_FULL : S_LOAD;
      end
      S_FLUSH: begin
        imem_we = 1'b1;
        w_next  = S_DONE;
      end
      S_FULL: begin
        if (w_xfer) begin
          w_next = S_ERROR;
        end
      end
      S_DONE: begin
        cpu_reset = 1'b0;
        load_done = 1'b1;
        if (reload) begin
          w_next = S_IDLE;
        end
      end
      S_ERROR: begin
        overflow_err = 1'b1;
        if (reload) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Byte assembly, write address and word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= 2'd0;
      r_asm   <= 32'd0;
      r_wdata <= 32'd0;
      r_addr  <= BASE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (w_xfer) begin
            if (w_emit) begin
              r_wdata <= w_word;
              r_asm   <= 32'd0;
              r_idx   <= 2'd0;
            end else begin
              r_asm <= w_word;
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        S_WRITE: begin
          // The top address is never stepped past; FULL takes over from here.
          if (r_addr != LAST_ADDR) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
          end
          r_count <= w_count_inc;
        end
        S_FLUSH: begin
          r_count <= w_count_inc;
        end
        S_DONE, S_ERROR: begin
          if (reload) begin
            r_idx   <= 2'd0;
            r_asm   <= 32'd0;
            r_wdata <= 32'd0;
            r_addr  <= BASE;
            r_count <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam logic [41:0] RST_VEC = {1'b0, 2'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_byte;
  logic          in_last;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          load_done;
  logic [AW:0]   word_count;
  logic          overflow_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  logic [31:0] exp_q[$];
  bit          exp_ovf;
  int          exp_count;

  instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .reload       (reload),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .word_count   (word_count),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: logs every memory write; the input must be stalled while writing.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1 && imem_we === 1'b1) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL in_ready_during_write: got %b want 0", in_ready);
      end
    end
  end

  function automatic logic [41:0] snap();
    return {imem_we, imem_addr, imem_wdata, word_count, cpu_reset, load_done, overflow_err, in_ready};
  endfunction

  // Reference: image bytes -> little-endian zero-padded words at addresses 0,1,...
  // capped at memory depth; anything beyond depth*4 bytes is an overflow.
  function automatic void build_model(input logic [7:0] img[$]);
    int n;
    int nw;
    logic [31:0] w;
    n = img.size();
    nw = (n + 3) / 4;
    exp_ovf = (n > 4 * DEPTH);
    if (nw > DEPTH) nw = DEPTH;
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k < n) w = w | (32'(img[4 * i + k]) << (8 * k));
      end
      exp_q.push_back(w);
    end
    exp_count = nw;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic last, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic push_image(input logic [7:0] img[$], input bit gaps);
    int t;
    for (int i = 0; i < img.size(); i++) push_byte(img[i], (i == img.size() - 1), gaps);
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while (!(load_done === 1'b1 || overflow_err === 1'b1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: load_done=%b overflow_err=%b want one set", load_done, overflow_err);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %h want %h", snap(), RST_VEC);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (snap() !== RST_VEC) begin
      errors++;
      $display("FAIL post_reset_idle: got %h want %h", snap(), RST_VEC);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] b[4];
    b[0] = 8'h01; b[1] = 8'h00; b[2] = 8'hA0; b[3] = 8'h10;
    clear_log();
    for (int i = 0; i < 4; i++) push_byte(b[i], (i == 3), 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd0, 32'h10A00001}) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h want 1 0 10a00001", imem_we, imem_addr, imem_wdata);
    end
    @(negedge clk);
    checks++;
    if ({load_done, cpu_reset, imem_we, in_ready, word_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL single_done: got done=%b cpu_rst=%b we=%b rdy=%b cnt=%0d want 1 0 0 0 1",
               load_done, cpu_reset, imem_we, in_ready, word_count);
    end
    checks++;
    if (wr_data_q.size() !== 1) begin
      errors++;
      $display("FAIL single_write_count: got %0d want 1", wr_data_q.size());
    end
    do_reload();
  endtask

  task automatic test_two_words();
    logic [7:0] img[$];
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    build_model(img);
    clear_log();
    push_image(img, 1'b0);
    checks++;
    if (wr_data_q.size() !== 2) begin
      errors++;
      $display("FAIL two_write_count: got %0d want 2", wr_data_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL two_word%0d: got addr=%0d data=%h want %0d %h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
        end
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] !== 5) begin
        errors++;
        $display("FAIL two_spacing: got %0d cycles want 5", wr_cyc_q[1] - wr_cyc_q[0]);
      end
    end
    checks++;
    if ({load_done, word_count} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL two_done: got done=%b cnt=%0d want 1 2", load_done, word_count);
    end
    do_reload();
  endtask

  task automatic test_padding();
    logic [7:0] img[$];
    for (int i = 0; i < 6; i++) img.push_back(8'h11 + 8'(i));
    clear_log();
    push_image(img, 1'b0);
    checks++;
    if (wr_data_q.size() !== 2) begin
      errors++;
      $display("FAIL pad_write_count: got %0d want 2", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'h14131211) begin
        errors++;
        $display("FAIL pad_word0: got addr=%0d data=%h want 0 14131211", wr_addr_q[0], wr_data_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 1 || wr_data_q[1] !== 32'h00001615) begin
        errors++;
        $display("FAIL pad_word1: got addr=%0d data=%h want 1 00001615", wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++;
    if (word_count !== 3'd2) begin
      errors++;
      $display("FAIL pad_count: got %0d want 2", word_count);
    end
    do_reload();
  endtask

  task automatic test_gapped();
    logic [7:0] img[$];
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    build_model(img);
    clear_log();
    push_image(img, 1'b1);
    checks++;
    if (wr_data_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL gap_write_count: got %0d want %0d", wr_data_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL gap_word%0d: got addr=%0d data=%h want %0d %h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
        end
      end
    end
    checks++;
    if ({load_done, word_count} !== {1'b1, 3'(exp_count)}) begin
      errors++;
      $display("FAIL gap_done: got done=%b cnt=%0d want 1 %0d", load_done, word_count, exp_count);
    end
    do_reload();
  endtask

  task automatic test_random_images();
    logic [7:0] img[$];
    int n;
    for (int r = 0; r < 6; r++) begin
      img.delete();
      n = $urandom_range(1, 4 * DEPTH);
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      build_model(img);
      clear_log();
      push_image(img, bit'($urandom_range(0, 1)));
      checks++;
      if (wr_data_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_write_count: got %0d want %0d", r, wr_data_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand%0d_word%0d: got addr=%0d data=%h want %0d %h", r, i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
          end
        end
      end
      checks++;
      if ({load_done, cpu_reset, overflow_err, word_count} !== {1'b1, 1'b0, 1'b0, 3'(exp_count)}) begin
        errors++;
        $display("FAIL rand%0d_done: got done=%b cpu_rst=%b ovf=%b cnt=%0d want 1 0 0 %0d",
                 r, load_done, cpu_reset, overflow_err, word_count, exp_count);
      end
      do_reload();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] img[$];
    for (int i = 0; i < 17; i++) img.push_back(8'($urandom));
    build_model(img);
    clear_log();
    push_image(img, 1'b0);
    checks++;
    if (wr_data_q.size() !== DEPTH) begin
      errors++;
      $display("FAIL ovf_write_count: got %0d want %0d", wr_data_q.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (wr_addr_q[i] !== i || wr_data_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL ovf_word%0d: got addr=%0d data=%h want %0d %h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
        end
      end
    end
    checks++;
    if ({overflow_err, cpu_reset, in_ready, load_done, word_count} !== {exp_ovf, 1'b1, 1'b1, 1'b0, 3'(DEPTH)}) begin
      errors++;
      $display("FAIL ovf_flags: got ovf=%b cpu_rst=%b rdy=%b done=%b cnt=%0d want 1 1 1 0 %0d",
               overflow_err, cpu_reset, in_ready, load_done, word_count, DEPTH);
    end
    push_byte(8'h5A, 1'b1, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_data_q.size() !== DEPTH || overflow_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drain: got writes=%0d ovf=%b want %0d 1", wr_data_q.size(), overflow_err, DEPTH);
    end
    do_reload();
    checks++;
    if (snap() !== RST_VEC) begin
      errors++;
      $display("FAIL ovf_reload: got %h want %h", snap(), RST_VEC);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] img[$];
    clear_log();
    push_byte(8'hDE, 1'b0, 1'b0);
    push_byte(8'hAD, 1'b0, 1'b0);
    push_byte(8'hBE, 1'b0, 1'b0);
    push_byte(8'hEF, 1'b0, 1'b0);
    in_valid = 1'b0;
    checks++;
    if (imem_we !== 1'b1 || imem_wdata !== 32'hEFBEADDE) begin
      errors++;
      $display("FAIL arst_pre_write: got we=%b data=%h want 1 efbeadde", imem_we, imem_wdata);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (snap() !== RST_VEC) begin
      errors++;
      $display("FAIL arst_mid_write: got %h want %h", snap(), RST_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_byte(8'hAA, 1'b0, 1'b0);
    push_byte(8'hBB, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (snap() !== RST_VEC) begin
      errors++;
      $display("FAIL arst_mid_word: got %h want %h", snap(), RST_VEC);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    img.push_back(8'h01);
    img.push_back(8'h02);
    img.push_back(8'h03);
    img.push_back(8'h04);
    push_image(img, 1'b0);
    checks++;
    if (wr_data_q.size() !== 1) begin
      errors++;
      $display("FAIL arst_fresh_count: got %0d want 1", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 0 || wr_data_q[0] !== 32'h04030201) begin
        errors++;
        $display("FAIL arst_fresh_word: got addr=%0d data=%h want 0 04030201", wr_addr_q[0], wr_data_q[0]);
      end
    end
    checks++;
    if ({load_done, word_count} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL arst_fresh_done: got done=%b cnt=%0d want 1 1", load_done, word_count);
    end
    do_reload();
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    in_last  = 1'b0;
    reload   = 1'b0;
    test_reset();
    test_single_word();
    test_two_words();
    test_padding();
    test_gapped();
    test_random_images();
    test_overflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
